// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: button indices (which double as the priority order,
// lowest index wins), channel count, default debounce length and the
// priority-pick helper shared by the conditioner files.
package button_conditioner_pkg;

  localparam int BTN_MID   = 0;
  localparam int BTN_UP    = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_DOWN  = 4;
  localparam int NUM_BTN   = 5;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_CNT_W           = 24;

  // Keep only the lowest set bit, i.e. the highest-priority request.
  function automatic logic [NUM_BTN-1:0] pick_highest(input logic [NUM_BTN-1:0] i_req);
    return i_req & (~i_req + NUM_BTN'(1));
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw push-button levels in, single-cycle press
// pulses and the held flag out. The master side drives the buttons, the
// slave side is the conditioner.
interface button_conditioner_if;

  logic btn_up;
  logic btn_left;
  logic btn_right;
  logic btn_down;
  logic btn_mid;

  logic b_up_add_out;
  logic b_left_subtract_out;
  logic b_right_multiply_out;
  logic b_down_square_out;
  logic b_mid_select_out;
  logic btn_held;

  modport master (
    output btn_up, btn_left, btn_right, btn_down, btn_mid,
    input  b_up_add_out, b_left_subtract_out, b_right_multiply_out,
           b_down_square_out, b_mid_select_out, btn_held
  );

  modport slave (
    input  btn_up, btn_left, btn_right, btn_down, btn_mid,
    output b_up_add_out, b_left_subtract_out, b_right_multiply_out,
           b_down_square_out, b_mid_select_out, btn_held
  );

endinterface

// File: rtl/button_conditioner_btn_debounce_ch.sv
// btn_debounce_ch: one button channel. Two-flop synchroniser, a
// disagreement counter that flips the stable level once the new level has
// persisted, and a one-cycle rise indication (stable & ~stable_d).
// The stable level flips DEBOUNCE_CYCLES edges after the synchroniser first
// samples a held new level; any cycle of agreement restarts the count.
module btn_debounce_ch
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise
);

  // Two synchroniser edges are already spent before the counter sees the
  // new level, so the flip happens when the count reaches DEBOUNCE_CYCLES-2.
  localparam logic [CNT_W-1:0] FLIP_AT = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic [CNT_W-1:0] r_cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive disagreement and flip the stable level once it lasts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (r_sync2 == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == FLIP_AT) begin
      r_cnt    <= '0;
      r_stable <= ~r_stable;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Delayed copy of the stable level for press-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable_d <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = r_stable & ~r_stable_d;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: five debounced push-button channels feeding a
// registered priority arbiter (mid > up > left > right > down) so at most
// one press pulse leaves per cycle; losing rises are dropped.
// Optional build macro BTN_RELEASE_LOCK_EN: after any pulse, further rises
// are suppressed until every debounced button has been released.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  button_conditioner_if.slave bus
);

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_stable;
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_rise_q;
  logic [NUM_BTN-1:0] w_grant;
  logic [NUM_BTN-1:0] r_pulse;
  logic               r_held;

  // Gather the raw buttons into a vector ordered by priority index.
  always_comb begin
    w_raw            = '0;
    w_raw[BTN_MID]   = bus.btn_mid;
    w_raw[BTN_UP]    = bus.btn_up;
    w_raw[BTN_LEFT]  = bus.btn_left;
    w_raw[BTN_RIGHT] = bus.btn_right;
    w_raw[BTN_DOWN]  = bus.btn_down;
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (w_raw[g]),
      .o_stable(w_stable[g]),
      .o_rise  (w_rise[g])
    );
  end

`ifdef BTN_RELEASE_LOCK_EN
  logic r_lock;

  // Lock after any pulse; unlock once all debounced levels are released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock <= 1'b0;
    end else if (|w_grant) begin
      r_lock <= 1'b1;
    end else if (w_stable == '0) begin
      r_lock <= 1'b0;
    end
  end

  assign w_rise_q = r_lock ? '0 : w_rise;
`else
  assign w_rise_q = w_rise;
`endif

  assign w_grant = pick_highest(w_rise_q);

  // Register the single winning pulse and the any-button-held flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulse <= '0;
      r_held  <= 1'b0;
    end else begin
      r_pulse <= w_grant;
      r_held  <= |w_stable;
    end
  end

  assign bus.b_mid_select_out     = r_pulse[BTN_MID];
  assign bus.b_up_add_out         = r_pulse[BTN_UP];
  assign bus.b_left_subtract_out  = r_pulse[BTN_LEFT];
  assign bus.b_right_multiply_out = r_pulse[BTN_RIGHT];
  assign bus.b_down_square_out    = r_pulse[BTN_DOWN];
  assign bus.btn_held             = r_held;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks with hand-computed timing for a
// 4-cycle debounce, then a random-bounce phase compared cycle by cycle
// against a sliding-window reference of the debounced levels.
// Build macro BTN_RELEASE_LOCK_EN selects the release-lock expectations.
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  localparam int D = 4;

  logic clk;
  logic rst_n;

  button_conditioner_if bus();

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (24)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  logic [4:0] obsPulse;
  logic [4:0] rawVec;
  assign obsPulse = {bus.b_down_square_out, bus.b_right_multiply_out,
                     bus.b_left_subtract_out, bus.b_up_add_out, bus.b_mid_select_out};
  assign rawVec   = {bus.btn_down, bus.btn_right, bus.btn_left, bus.btn_up, bus.btn_mid};

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] hist [0:D];
  logic [4:0] mStable;
  logic [4:0] mStableD;
  logic [4:0] mRise;
  logic [4:0] mGrant;
  logic [4:0] mFlip;
  logic       mLock;
  logic [4:0] expPulse;
  logic       expHeld;
  int         modelPressCount;

  // Reference: a level flips when the last D-1 samples feeding the window all disagree with it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= D; k++) hist[k] = '0;
      mStable         = '0;
      mStableD        = '0;
      mLock           = 1'b0;
      expPulse        = '0;
      expHeld         = 1'b0;
      modelPressCount = 0;
    end else begin
      mRise = mStable & ~mStableD;
`ifdef BTN_RELEASE_LOCK_EN
      if (mLock) mRise = '0;
`endif
      mGrant = '0;
      for (int i = 0; i < 5; i++) begin
        if (mRise[i] && mGrant == '0) mGrant[i] = 1'b1;
      end
      if (mGrant != '0) mLock = 1'b1;
      else if (mStable == '0) mLock = 1'b0;
      if (mGrant != '0) modelPressCount++;
      expPulse = mGrant;
      expHeld  = |mStable;
      for (int k = D; k >= 1; k--) hist[k] = hist[k-1];
      hist[0] = rawVec;
      mFlip = '1;
      for (int k = 2; k <= D; k++) mFlip &= (hist[k] ^ mStable);
      mStableD = mStable;
      mStable  = mStable ^ mFlip;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setRaw(input logic [4:0] raw);
    bus.btn_mid   = raw[0];
    bus.btn_up    = raw[1];
    bus.btn_left  = raw[2];
    bus.btn_right = raw[3];
    bus.btn_down  = raw[4];
  endtask

  task automatic applyStimulus(input logic [4:0] raw);
    @(negedge clk);
    setRaw(raw);
  endtask

  task automatic waitCycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic countPulses(input int k, output int n, output logic [4:0] seen, output logic heldSeen);
    n = 0;
    seen = '0;
    heldSeen = 1'b0;
    repeat (k) begin
      @(negedge clk);
      n += $countones(obsPulse);
      seen |= obsPulse;
      heldSeen |= bus.btn_held;
    end
  endtask

  int         n;
  int         nAcc;
  logic [4:0] seen;
  logic       heldSeen;
  logic       heldAcc;
  logic [4:0] lvl;
  int         remain [5];
  int         dutPulses;

  initial begin
    rst_n = 1'b0;
    setRaw(5'b00000);
    waitCycles(3);
    checkOutput("reset_pulses", 32'(obsPulse), 32'h0);
    checkOutput("reset_held", 32'(bus.btn_held), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    waitCycles(5);

    applyStimulus(5'b00100);
    waitCycles(5);
    checkOutput("left_early", 32'(obsPulse), 32'h0);
    checkOutput("left_held_early", 32'(bus.btn_held), 32'h0);
    waitCycles(1);
    checkOutput("left_pulse", 32'(obsPulse), 32'h04);
    checkOutput("left_held", 32'(bus.btn_held), 32'h1);
    waitCycles(1);
    checkOutput("left_one_cycle", 32'(obsPulse), 32'h0);
    countPulses(20, n, seen, heldSeen);
    checkOutput("left_no_repeat", 32'(n), 32'h0);
    applyStimulus(5'b00000);
    countPulses(5, n, seen, heldSeen);
    checkOutput("left_release_no_pulse", 32'(n), 32'h0);
    checkOutput("left_release_held_lat", 32'(bus.btn_held), 32'h1);
    waitCycles(1);
    checkOutput("left_release_held", 32'(bus.btn_held), 32'h0);
    waitCycles(3);

    nAcc = 0;
    heldAcc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus((i % 2 == 0) ? 5'b00010 : 5'b00000);
      nAcc += $countones(obsPulse);
      heldAcc |= bus.btn_held;
    end
    applyStimulus(5'b00000);
    countPulses(15, n, seen, heldSeen);
    checkOutput("up_glitch_pulses", 32'(nAcc + n), 32'h0);
    checkOutput("up_glitch_held", 32'(heldAcc | heldSeen), 32'h0);

    applyStimulus(5'b01001);
    waitCycles(5);
    checkOutput("mid_right_early", 32'(obsPulse), 32'h0);
    waitCycles(1);
    checkOutput("mid_wins", 32'(obsPulse), 32'h01);
    countPulses(20, n, seen, heldSeen);
    checkOutput("right_dropped", 32'(seen), 32'h0);
    applyStimulus(5'b00000);
    waitCycles(10);

    @(negedge clk);
    rst_n = 1'b0;
    setRaw(5'b10000);
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(5);
    checkOutput("down_reset_early", 32'(obsPulse), 32'h0);
    waitCycles(1);
    checkOutput("down_reset_pulse", 32'(obsPulse), 32'h10);
    countPulses(10, n, seen, heldSeen);
    checkOutput("down_reset_once", 32'(n), 32'h0);
    checkOutput("down_held_before_reset", 32'(bus.btn_held), 32'h1);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset_held", 32'(bus.btn_held), 32'h0);
    checkOutput("async_reset_pulses", 32'(obsPulse), 32'h0);
    setRaw(5'b00000);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(5);

    applyStimulus(5'b10000);
    waitCycles(3);
    #1 rst_n = 1'b0;
    #1 checkOutput("mid_debounce_reset_out", 32'({obsPulse, bus.btn_held}), 32'h0);
    setRaw(5'b00000);
    waitCycles(2);
    rst_n = 1'b1;
    countPulses(15, n, seen, heldSeen);
    checkOutput("mid_debounce_no_pulse", 32'(n), 32'h0);

    applyStimulus(5'b00010);
    waitCycles(6);
    checkOutput("lock_up_pulse", 32'(obsPulse), 32'h02);
    waitCycles(4);
    applyStimulus(5'b01010);
    countPulses(15, n, seen, heldSeen);
`ifdef BTN_RELEASE_LOCK_EN
    checkOutput("lock_right_suppressed", 32'(n), 32'h0);
`else
    checkOutput("nolock_right_pulse", 32'(seen), 32'h08);
    checkOutput("nolock_right_count", 32'(n), 32'h1);
`endif
    applyStimulus(5'b00000);
    waitCycles(10);
    applyStimulus(5'b01000);
    waitCycles(5);
    checkOutput("right_after_release_early", 32'(obsPulse), 32'h0);
    waitCycles(1);
    checkOutput("right_after_release", 32'(obsPulse), 32'h08);
    applyStimulus(5'b00000);
    waitCycles(10);

    @(negedge clk);
    rst_n = 1'b0;
    waitCycles(2);
    rst_n = 1'b1;
    lvl = '0;
    for (int i = 0; i < 5; i++) remain[i] = int'($urandom_range(1, 10));
    dutPulses = 0;
    for (int cyc = 0; cyc < 2040; cyc++) begin
      @(negedge clk);
      checkOutput("rand_onehot0", 32'($onehot0(obsPulse)), 32'h1);
      checkOutput("rand_pulse", 32'(obsPulse), 32'(expPulse));
      checkOutput("rand_held", 32'(bus.btn_held), 32'(expHeld));
      dutPulses += $countones(obsPulse);
      if (cyc < 2000) begin
        for (int i = 0; i < 5; i++) begin
          remain[i]--;
          if (remain[i] <= 0) begin
            lvl[i] = ~lvl[i];
            remain[i] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3))
                                                    : int'($urandom_range(6, 25));
          end
        end
        setRaw(lvl);
      end else begin
        setRaw(5'b00000);
      end
    end
    checkOutput("rand_press_count", 32'(dutPulses), 32'(modelPressCount));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
